match_tracker: RTL and testbench
================================

# match_tracker

Downstream stage of the multi-mode counter: watches the counter's `GAMEOVER`/`WHO` outputs, scores each finished game for the winner or loser side, and declares a match champion once one side reaches `MATCH_GAMES` wins. It issues a one-cycle `restart` pulse that drives the counter's `INIT` to start the next game. It also presents each game result to a display/logger through a valid/ack handshake.

## Interface

- `MATCH_GAMES`, 3, games one side must win to take the match; legal range 1..(2^`SCORE_W`-1).
- `SCORE_W`, 3, width of each score register.

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `GAMEOVER`  in  1  from counter; may stay high for several cycles.
- `WHO`  in  2  from counter; 2'b01 = winner side, 2'b10 = loser side; 00/11 are invalid.
- `game_ack`  in  1  consumer accepts the current `game_valid` result.
- `match_ack`  in  1  clears a finished match.
- `restart`  out  1  one-cycle pulse; connects to counter `INIT`.
- `game_valid`  out  1  a new game result is pending.
- `game_who`  out  2  `WHO` latched for the pending result.
- `score_w`  out  `SCORE_W`  games won by the winner side.
- `score_l`  out  `SCORE_W`  games won by the loser side.
- `match_over`  out  1  match finished; high while in DONE.
- `champ`  out  2  match winner (01/10); 00 when `match_over`=0.
- `err`  out  1  sticky: invalid `WHO` or handshake overrun.

## Operation

- Edge detect: register `go_q` ← `GAMEOVER`; `rise` = `GAMEOVER` & ~`go_q`. A held `GAMEOVER` counts once.
- States:
  - PLAY (reset state).
  - DONE.
- PLAY, `rise` with `WHO`=01:
  - `score_w`+1.
  - `game_who`←01, `game_valid`←1, `restart` pulses.
  - If the new `score_w`==`MATCH_GAMES`: go to DONE, `champ`←01, and suppress `restart`.
- PLAY, `rise` with `WHO`=10: same as above, but on `score_l` and champ 10.
- `rise` with `WHO`=00/11: no score change, no `restart`, no `game_valid`, `err`←1.
- Handshake:
  - `game_valid` stays high until the cycle after `game_ack` is sampled high.
  - `game_who` is stable while valid.
  - A scored `rise` while `game_valid`=1 and `game_ack`=0:
    - Scores update.
    - `game_who` is overwritten.
    - `game_valid` stays 1.
    - `err`←1 (overrun).
  - `game_ack` and a scored `rise` in the same cycle: the new result wins, so `game_valid` stays 1 with the new `game_who`; no overrun.
- DONE:
  - `rise` is ignored; no score change, no `restart`, no `err`.
  - `match_ack` → scores←0, `champ`←00, `match_over`←0, `restart` pulse, go to PLAY. `game_valid` and `err` are unaffected.
  - `match_ack` in PLAY has no effect.
  - `match_ack` and `rise` in the same DONE cycle: the ack is processed and the rise is discarded. `go_q` still updates, so that level is not re-detected.
- Scores never exceed `MATCH_GAMES`, so no wrap is possible.
- `err` clears only on reset.

## Timing

- Reset values: `restart`=0, `game_valid`=0, `game_who`=00, `score_w`=0, `score_l`=0, `match_over`=0, `champ`=00, `err`=0, `go_q`=0, state PLAY.
- Reset is asynchronous: all outputs go to these values immediately on `reset` low, including mid-game and in DONE. Operation resumes on the first rising edge after `reset` returns high.
- If `GAMEOVER` is already high when reset deasserts, it counts as a `rise` on the first edge.
- Latency:
  - `GAMEOVER` sampled high at edge k (`go_q`=0) → scores, `game_valid`, `game_who`, `match_over`, `champ` update at edge k.
  - `restart` is high for exactly the cycle between edges k and k+1.
- `game_ack` sampled at edge j → `game_valid` is 0 after edge j.
- `match_ack` sampled at edge j → cleared outputs after edge j; `restart` is high between j and j+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan

- Reset then idle: `reset` low for 2 cycles, inputs 0 → all outputs 0, state PLAY. Assert `reset` low mid-game with `score_w`=2 → outputs 0 immediately.
- Single game, winner side: `GAMEOVER` high for 3 cycles with `WHO`=01 →
  - `score_w`=1, `game_valid`=1, `game_who`=01, one `restart` pulse only.
  - `game_ack` for 1 cycle → `game_valid`=0.
- Full match, `MATCH_GAMES`=3: games W, L, W, W, each acked →
  - `score_w`=3, `score_l`=1, `match_over`=1, `champ`=01.
  - Only 3 `restart` pulses.
  - A 5th `GAMEOVER` → no change.
  - `match_ack` → scores 0, `champ`=00, one `restart` pulse.
- Invalid WHO: `GAMEOVER` rise with `WHO`=11 → scores unchanged, no `restart`, `err`=1 and it persists.
- Overrun: two L games with no `game_ack` → `score_l`=2, `game_who`=10, `game_valid`=1, `err`=1.
- Simultaneous events:
  - `game_ack` together with a new W rise → `game_valid` stays 1, `err` stays 0.
  - In DONE, `match_ack` together with a rise → scores 0, PLAY, one `restart` pulse, rise not scored.

Source files
------------

// File: rtl/match_tracker.sv
// Scores finished games from the multi-mode counter, declares a match champion
// and hands each game result to a consumer through a valid/ack handshake.
module match_tracker #(
  parameter int MATCH_GAMES = 3,
  parameter int SCORE_W     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               GAMEOVER,
  input  logic [1:0]         WHO,
  input  logic               game_ack,
  input  logic               match_ack,
  output logic               restart,
  output logic               game_valid,
  output logic [1:0]         game_who,
  output logic [SCORE_W-1:0] score_w,
  output logic [SCORE_W-1:0] score_l,
  output logic               match_over,
  output logic [1:0]         champ,
  output logic               err
);

  typedef enum logic [0:0] {
    PLAY = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_ONE  = {{(SCORE_W-1){1'b0}}, 1'b1};
  localparam logic [SCORE_W-1:0] MATCH_TGT  = MATCH_GAMES[SCORE_W-1:0];
  localparam logic [SCORE_W-1:0] SCORE_ZERO = {SCORE_W{1'b0}};

  state_t             state_q;
  logic               go_q;
  logic               restart_q;
  logic               game_valid_q;
  logic [1:0]         game_who_q;
  logic [SCORE_W-1:0] score_w_q;
  logic [SCORE_W-1:0] score_l_q;
  logic               match_over_q;
  logic [1:0]         champ_q;
  logic               err_q;

  logic               rise_s;
  logic               overrun_s;
  logic [SCORE_W-1:0] w_inc_s;
  logic [SCORE_W-1:0] l_inc_s;

  // Edge detection and incremented scores feeding the state machine.
  always_comb begin
    rise_s    = GAMEOVER & ~go_q;
    overrun_s = game_valid_q & ~game_ack;
    w_inc_s   = score_w_q + SCORE_ONE;
    l_inc_s   = score_l_q + SCORE_ONE;
  end

  // Match state machine with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= PLAY;
      go_q         <= 1'b0;
      restart_q    <= 1'b0;
      game_valid_q <= 1'b0;
      game_who_q   <= 2'b00;
      score_w_q    <= SCORE_ZERO;
      score_l_q    <= SCORE_ZERO;
      match_over_q <= 1'b0;
      champ_q      <= 2'b00;
      err_q        <= 1'b0;
    end else begin
      go_q      <= GAMEOVER;
      restart_q <= 1'b0;
      // An ack drops valid unless a newly scored game re-raises it below.
      if (game_ack) begin
        game_valid_q <= 1'b0;
      end
      case (state_q)
        PLAY: begin
          if (rise_s) begin
            case (WHO)
              2'b01: begin
                score_w_q    <= w_inc_s;
                game_who_q   <= 2'b01;
                game_valid_q <= 1'b1;
                if (overrun_s) begin
                  err_q <= 1'b1;
                end
                if (w_inc_s == MATCH_TGT) begin
                  state_q      <= DONE;
                  champ_q      <= 2'b01;
                  match_over_q <= 1'b1;
                end else begin
                  restart_q <= 1'b1;
                end
              end
              2'b10: begin
                score_l_q    <= l_inc_s;
                game_who_q   <= 2'b10;
                game_valid_q <= 1'b1;
                if (overrun_s) begin
                  err_q <= 1'b1;
                end
                if (l_inc_s == MATCH_TGT) begin
                  state_q      <= DONE;
                  champ_q      <= 2'b10;
                  match_over_q <= 1'b1;
                end else begin
                  restart_q <= 1'b1;
                end
              end
              default: begin
                err_q <= 1'b1;
              end
            endcase
          end
        end
        DONE: begin
          // Rises are discarded here; go_q still tracks GAMEOVER above.
          if (match_ack) begin
            state_q      <= PLAY;
            score_w_q    <= SCORE_ZERO;
            score_l_q    <= SCORE_ZERO;
            champ_q      <= 2'b00;
            match_over_q <= 1'b0;
            restart_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= PLAY;
        end
      endcase
    end
  end

  assign restart    = restart_q;
  assign game_valid = game_valid_q;
  assign game_who   = game_who_q;
  assign score_w    = score_w_q;
  assign score_l    = score_l_q;
  assign match_over = match_over_q;
  assign champ      = champ_q;
  assign err        = err_q;

endmodule

// File: tb/tb_match_tracker.sv
// Directed self-checking bench for match_tracker with MATCH_GAMES=3.
module tb_match_tracker;

  logic       clk;
  logic       reset;
  logic       GAMEOVER;
  logic [1:0] WHO;
  logic       game_ack;
  logic       match_ack;
  logic       restart;
  logic       game_valid;
  logic [1:0] game_who;
  logic [2:0] score_w;
  logic [2:0] score_l;
  logic       match_over;
  logic [1:0] champ;
  logic       err;

  int checks;
  int errors;
  int rcnt;

  match_tracker #(.MATCH_GAMES(3), .SCORE_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .GAMEOVER   (GAMEOVER),
    .WHO        (WHO),
    .game_ack   (game_ack),
    .match_ack  (match_ack),
    .restart    (restart),
    .game_valid (game_valid),
    .game_who   (game_who),
    .score_w    (score_w),
    .score_l    (score_l),
    .match_over (match_over),
    .champ      (champ),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (restart === 1'b1) rcnt++;
  endtask

  task automatic game(input logic [1:0] who, input logic ack);
    GAMEOVER = 1'b1;
    WHO      = who;
    cyc();
    GAMEOVER = 1'b0;
    WHO      = 2'b00;
    cyc();
    if (ack) begin
      game_ack = 1'b1;
      cyc();
      game_ack = 1'b0;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_restart"}, {7'd0, restart}, 8'd0);
    chk({tag, "_valid"}, {7'd0, game_valid}, 8'd0);
    chk({tag, "_who"}, {6'd0, game_who}, 8'd0);
    chk({tag, "_sw"}, {5'd0, score_w}, 8'd0);
    chk({tag, "_sl"}, {5'd0, score_l}, 8'd0);
    chk({tag, "_mover"}, {7'd0, match_over}, 8'd0);
    chk({tag, "_champ"}, {6'd0, champ}, 8'd0);
    chk({tag, "_err"}, {7'd0, err}, 8'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rcnt      = 0;
    reset     = 1'b0;
    GAMEOVER  = 1'b0;
    WHO       = 2'b00;
    game_ack  = 1'b0;
    match_ack = 1'b0;
    cyc();
    cyc();
    chk_idle("rst");
    reset = 1'b1;

    // Single winner game with GAMEOVER held three cycles.
    GAMEOVER = 1'b1;
    WHO      = 2'b01;
    cyc();
    chk("g1_sw", {5'd0, score_w}, 8'd1);
    chk("g1_valid", {7'd0, game_valid}, 8'd1);
    chk("g1_who", {6'd0, game_who}, 8'd1);
    chk("g1_restart", {7'd0, restart}, 8'd1);
    cyc();
    cyc();
    GAMEOVER = 1'b0;
    WHO      = 2'b00;
    cyc();
    chk("g1_sw_held", {5'd0, score_w}, 8'd1);
    chk("g1_rcnt", rcnt[7:0], 8'd1);
    game_ack = 1'b1;
    cyc();
    game_ack = 1'b0;
    chk("g1_acked", {7'd0, game_valid}, 8'd0);

    // Rest of the match: L, W, W.
    game(2'b10, 1'b1);
    game(2'b01, 1'b1);
    game(2'b01, 1'b1);
    chk("m_sw", {5'd0, score_w}, 8'd3);
    chk("m_sl", {5'd0, score_l}, 8'd1);
    chk("m_over", {7'd0, match_over}, 8'd1);
    chk("m_champ", {6'd0, champ}, 8'd1);
    chk("m_rcnt", rcnt[7:0], 8'd3);
    game(2'b10, 1'b0);
    chk("m5_sl", {5'd0, score_l}, 8'd1);
    chk("m5_valid", {7'd0, game_valid}, 8'd0);
    chk("m5_rcnt", rcnt[7:0], 8'd3);
    chk("m5_err", {7'd0, err}, 8'd0);
    match_ack = 1'b1;
    cyc();
    match_ack = 1'b0;
    chk("mack_sw", {5'd0, score_w}, 8'd0);
    chk("mack_sl", {5'd0, score_l}, 8'd0);
    chk("mack_champ", {6'd0, champ}, 8'd0);
    chk("mack_over", {7'd0, match_over}, 8'd0);
    chk("mack_restart", {7'd0, restart}, 8'd1);
    cyc();
    chk("mack_rcnt", rcnt[7:0], 8'd4);

    // match_ack is ignored while playing.
    match_ack = 1'b1;
    game(2'b01, 1'b1);
    match_ack = 1'b0;
    chk("pack_sw", {5'd0, score_w}, 8'd1);

    // Asynchronous reset mid-game with score_w=2.
    game(2'b01, 1'b1);
    chk("pre_rst_sw", {5'd0, score_w}, 8'd2);
    #3 reset = 1'b0;
    #1;
    chk_idle("async");
    reset = 1'b1;

    // Reach DONE, then match_ack together with a rise.
    game(2'b01, 1'b1);
    game(2'b01, 1'b1);
    game(2'b01, 1'b1);
    chk("d_over", {7'd0, match_over}, 8'd1);
    rcnt      = 0;
    match_ack = 1'b1;
    GAMEOVER  = 1'b1;
    WHO       = 2'b01;
    cyc();
    match_ack = 1'b0;
    chk("dsim_sw", {5'd0, score_w}, 8'd0);
    chk("dsim_over", {7'd0, match_over}, 8'd0);
    chk("dsim_valid", {7'd0, game_valid}, 8'd0);
    cyc();
    chk("dsim_held_sw", {5'd0, score_w}, 8'd0);
    chk("dsim_rcnt", rcnt[7:0], 8'd1);
    GAMEOVER = 1'b0;
    WHO      = 2'b00;
    cyc();

    // game_ack together with a new winner rise.
    game(2'b01, 1'b0);
    game_ack = 1'b1;
    GAMEOVER = 1'b1;
    WHO      = 2'b01;
    cyc();
    game_ack = 1'b0;
    GAMEOVER = 1'b0;
    WHO      = 2'b00;
    chk("ackrise_valid", {7'd0, game_valid}, 8'd1);
    chk("ackrise_err", {7'd0, err}, 8'd0);
    chk("ackrise_sw", {5'd0, score_w}, 8'd2);
    game_ack = 1'b1;
    cyc();
    game_ack = 1'b0;

    // Invalid WHO sets a sticky error only.
    rcnt = 0;
    game(2'b11, 1'b0);
    chk("inv_sw", {5'd0, score_w}, 8'd2);
    chk("inv_sl", {5'd0, score_l}, 8'd0);
    chk("inv_valid", {7'd0, game_valid}, 8'd0);
    chk("inv_rcnt", rcnt[7:0], 8'd0);
    chk("inv_err", {7'd0, err}, 8'd1);
    cyc();
    cyc();
    chk("inv_err_sticky", {7'd0, err}, 8'd1);

    // Overrun: two loser games with no ack.
    do_reset();
    game(2'b10, 1'b0);
    chk("ovr_err0", {7'd0, err}, 8'd0);
    game(2'b10, 1'b0);
    chk("ovr_sl", {5'd0, score_l}, 8'd2);
    chk("ovr_who", {6'd0, game_who}, 8'd2);
    chk("ovr_valid", {7'd0, game_valid}, 8'd1);
    chk("ovr_err", {7'd0, err}, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
